// File: rtl/mul_operand_sequencer.sv
// rtl/mul_operand_sequencer.sv - operand-pair FIFO and start/load/restart sequencer for the repeated-addition multiplier
// Optional abort on a stuck multiplier is compiled in with `define MUL_SEQ_TIMEOUT_EN.
module mul_operand_sequencer #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  output logic                     mul_start,
  output logic [WIDTH-1:0]         mul_data,
  input  logic                     mul_done,
  output logic                     mul_restart,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [7:0]               op_count,
  output logic                     timeout_err
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] L_FULL = (PW+1)'(DEPTH);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_LOAD_A  = 3'd2;
  localparam logic [2:0] S_LOAD_B  = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;
  localparam logic [2:0] S_RELEASE = 3'd5;

  logic [2:0]       r_state;
  logic [2:0]       w_next;
  logic [WIDTH-1:0] r_mem_a [DEPTH];
  logic [WIDTH-1:0] r_mem_b [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_level;
  logic [WIDTH-1:0] r_mul_data;
  logic [WIDTH-1:0] w_next_data;
  logic [7:0]       r_op_count;
  logic             w_push;
  logic             w_pop;
  logic             w_timeout;

  // Full blocks the producer even when a pop happens this cycle, so in_ready is a pure level decode.
  assign w_push = in_valid && (r_level != L_FULL);
  // The head is consumed on the same edge the controller loads B.
  assign w_pop  = (r_state == S_LOAD_B);

  assign in_ready    = (r_level != L_FULL);
  assign fifo_level  = r_level;
  assign mul_start   = (r_state == S_START);
  assign mul_restart = (r_state == S_RELEASE);
  assign busy        = (r_state != S_IDLE);
  assign mul_data    = r_mul_data;
  assign op_count    = r_op_count;

  // Operand storage: data only, no reset needed since the level gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr] <= in_a;
      r_mem_b[r_wr_ptr] <= in_b;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

`ifdef MUL_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_tcnt;
  logic          r_timeout_err;

  // Abort on the TIMEOUT-th WAIT cycle that still has no done.
  assign w_timeout   = (r_state == S_WAIT) && !mul_done && (r_tcnt == TW'(TIMEOUT - 1));
  assign timeout_err = r_timeout_err;

  // WAIT cycle counter (held at zero outside WAIT) and sticky abort flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tcnt        <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state != S_WAIT) r_tcnt <= '0;
      else if (!w_timeout)   r_tcnt <= r_tcnt + 1'b1;
      if (w_timeout) r_timeout_err <= 1'b1;
    end
  end
`else
  assign w_timeout   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Next state and the bus value for the next cycle; mul_data is registered so it never follows inputs.
  always_comb begin
    w_next      = r_state;
    w_next_data = r_mul_data;
    case (r_state)
      S_IDLE: begin
        w_next_data = '0;
        if (r_level != '0) begin
          w_next      = S_START;
          w_next_data = r_mem_a[r_rd_ptr];
        end
      end
      S_START: begin
        w_next      = S_LOAD_A;
        w_next_data = r_mem_a[r_rd_ptr];
      end
      S_LOAD_A: begin
        w_next      = S_LOAD_B;
        w_next_data = r_mem_b[r_rd_ptr];
      end
      S_LOAD_B: begin
        // B stays on the bus through WAIT even though the head is popped now.
        w_next = S_WAIT;
      end
      S_WAIT: begin
        if (mul_done || w_timeout) begin
          w_next      = S_RELEASE;
          w_next_data = '0;
        end
      end
      S_RELEASE: begin
        w_next_data = '0;
        if (!mul_done) w_next = S_IDLE;
      end
      default: begin
        w_next      = S_IDLE;
        w_next_data = '0;
      end
    endcase
  end

  // Sequencer state, bus register and completed-operation counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_mul_data <= '0;
      r_op_count <= '0;
    end else begin
      r_state    <= w_next;
      r_mul_data <= w_next_data;
      if ((r_state == S_WAIT) && mul_done) r_op_count <= r_op_count + 1'b1;
    end
  end

endmodule
